// File: rtl/gshare_bht.sv
// gshare_bht: parametrised branch history table with a speculative global
// history register (GHR) and a row-sweep initialiser.
//
// Ports
//   clk_i             clock, all state changes on the rising edge
//   rst_i             synchronous active-high reset
//   flush_i           re-initialise the table and clear the GHR
//   debug_mode_i      drop counter updates (GHR unaffected)
//   vpc_i             fetch PC, predictions are combinational from it
//   spec_valid_i      shift spec_taken_i into the GHR
//   spec_taken_i      predicted direction
//   upd_valid_i       resolved conditional branch
//   upd_pc_i          branch PC
//   upd_taken_i       actual direction
//   upd_hist_i        GHR snapshot taken at prediction time
//   upd_mispredict_i  repair the GHR from upd_hist_i / upd_taken_i
//   pred_valid_o      per-slot prediction valid
//   pred_taken_o      per-slot counter MSB
//   pred_hist_o       current GHR
//   ready_o           initialisation complete
//
// state   | meaning
// S_INIT  | sweeping rows, writing the weakly-not-taken value; inputs ignored
// S_READY | normal prediction / update / GHR operation
module gshare_bht #(
   parameter int unsigned NR_ENTRIES      = 1024,
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned CTR_WIDTH       = 2,
   parameter int unsigned HIST_LEN        = 8,
   parameter int unsigned MODE            = 1,
   parameter int unsigned OFFSET          = 1,
   parameter int unsigned VLEN            = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       debug_mode_i,
   input  logic [VLEN-1:0]            vpc_i,
   input  logic                       spec_valid_i,
   input  logic                       spec_taken_i,
   input  logic                       upd_valid_i,
   input  logic [VLEN-1:0]            upd_pc_i,
   input  logic                       upd_taken_i,
   input  logic [HIST_LEN-1:0]        upd_hist_i,
   input  logic                       upd_mispredict_i,
   output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
   output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
   output logic [HIST_LEN-1:0]        pred_hist_o,
   output logic                       ready_o
);

   localparam int unsigned ROWS      = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned ROW_BITS  = $clog2(ROWS);
   localparam int unsigned BANK_BITS = $clog2(INSTR_PER_FETCH);
   localparam int unsigned BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

   localparam logic [ROW_BITS-1:0]  ROW_LAST = ROW_BITS'(ROWS - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

   typedef enum logic {S_INIT, S_READY} state_e;

   state_e               state_q;
   logic [ROW_BITS-1:0]  r_q;
   logic [HIST_LEN-1:0]  ghr_q;
   logic                 ready_q;

   logic [CTR_WIDTH-1:0] ctr_q [INSTR_PER_FETCH][ROWS];

   logic [VLEN-1:0]      vpc_sh;
   logic [VLEN-1:0]      upc_sh;
   logic [ROW_BITS-1:0]  prow;
   logic [ROW_BITS-1:0]  urow;
   logic [BANK_W-1:0]    ubank;
   logic [CTR_WIDTH-1:0] upd_old;
   logic [CTR_WIDTH-1:0] upd_new;
   logic                 init_we;
   logic                 upd_we;
   logic                 unused_pc;

   assign vpc_sh = vpc_i >> OFFSET;
   assign upc_sh = upd_pc_i >> OFFSET;

   // Only a window of each PC feeds the index; the rest is deliberately dropped.
   assign unused_pc = ^{vpc_sh, upc_sh};

   // History is zero-extended to the row width before the XOR fold.
   always_comb begin
      prow = vpc_sh[BANK_BITS +: ROW_BITS];
      urow = upc_sh[BANK_BITS +: ROW_BITS];
      if (MODE == 1) begin
         prow = prow ^ ROW_BITS'(ghr_q);
         urow = urow ^ ROW_BITS'(upd_hist_i);
      end
   end

   generate
      if (BANK_BITS > 0) begin : g_bank
         assign ubank = upc_sh[BANK_W-1:0];
      end else begin : g_nobank
         assign ubank = '0;
      end
   endgenerate

   assign upd_old = ctr_q[ubank][urow];

   always_comb begin
      upd_new = upd_old;
      if (upd_taken_i) begin
         if (upd_old != CTR_MAX) upd_new = upd_old + CTR_WIDTH'(1);
      end else begin
         if (upd_old != '0) upd_new = upd_old - CTR_WIDTH'(1);
      end
   end

   // rst/flush take priority over any table write in the same cycle.
   assign init_we = (state_q == S_INIT) && !rst_i && !flush_i;
   assign upd_we  = (state_q == S_READY) && upd_valid_i && !debug_mode_i
                    && !rst_i && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         state_q <= S_INIT;
         r_q     <= '0;
         ghr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               r_q <= r_q + ROW_BITS'(1);
               if (r_q == ROW_LAST) begin
                  state_q <= S_READY;
                  ready_q <= 1'b1;
               end
            end
            S_READY: begin
               // A repair supersedes any speculative shift in the same cycle.
               if (upd_valid_i && upd_mispredict_i)
                  ghr_q <= HIST_LEN'({upd_hist_i, upd_taken_i});
               else if (spec_valid_i)
                  ghr_q <= HIST_LEN'({ghr_q, spec_taken_i});
            end
            default: begin
               state_q <= S_INIT;
               r_q     <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Table storage has no reset; the init sweep defines its contents and
   // predictions are masked until the sweep is complete.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < int'(INSTR_PER_FETCH); b++) begin
         if (init_we)
            ctr_q[b][r_q] <= CTR_INIT;
         else if (upd_we && (ubank == BANK_W'(b)))
            ctr_q[b][urow] <= upd_new;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
         pred_taken_o[i] = ready_q & ctr_q[i][prow][CTR_WIDTH-1];
      end
   end

   assign pred_valid_o = {INSTR_PER_FETCH{ready_q}};
   assign pred_hist_o  = ghr_q;
   assign ready_o      = ready_q;

endmodule

// File: doc/gshare_bht.md
# gshare_bht

Parametrised branch history table for the CVA6 frontend. It succeeds the fixed bimodal BHT: counter width, history length and indexing mode are configurable. It keeps a speculative global history register (GHR) and repairs it on mispredict. The table is initialised by a row-sweep state machine after reset or flush. Prediction reads are combinational from `vpc_i`. Updates arrive from the backend on resolved conditional branches.

## Interface
- `NR_ENTRIES`, 1024: total counters; power of two.
- `INSTR_PER_FETCH`, 2: banks, one prediction per fetch slot; power of two.
- `CTR_WIDTH`, 2: saturating counter width, 1..4.
- `HIST_LEN`, 8: GHR length; must be at most `ROW_BITS = log2(NR_ENTRIES/INSTR_PER_FETCH)`.
- `MODE`, 1: 0 = bimodal (history ignored), 1 = gshare.
- `OFFSET`, 1: low PC bits dropped (halfword-aligned RVC).
- `VLEN`, 64: virtual address width.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  re-initialise the table and clear the GHR.
- `debug_mode_i`  in  1  when high, updates are dropped.
- `vpc_i`  in  VLEN  fetch virtual PC.
- `spec_valid_i`  in  1  a conditional branch was predicted this cycle; shift `spec_taken_i` into the GHR.
- `spec_taken_i`  in  1  predicted direction.
- `upd_valid_i`  in  1  resolved conditional branch.
- `upd_pc_i`  in  VLEN  branch PC.
- `upd_taken_i`  in  1  actual direction.
- `upd_hist_i`  in  HIST_LEN  GHR snapshot taken at prediction time.
- `upd_mispredict_i`  in  1  direction was mispredicted; repair the GHR.
- `pred_valid_o`  out  INSTR_PER_FETCH  per-slot prediction valid.
- `pred_taken_o`  out  INSTR_PER_FETCH  per-slot counter MSB.
- `pred_hist_o`  out  HIST_LEN  current `ghr_q`, carried down the pipe with the branch.
- `ready_o`  out  1  initialisation complete.

## Operation
**Indexing**
- Bank: `pc[OFFSET +: log2(INSTR_PER_FETCH)]`.
- Raw row: `pc[OFFSET+log2(INSTR_PER_FETCH) +: ROW_BITS]`.
- In gshare mode, the low `HIST_LEN` bits of the raw row are XORed with the history. Prediction uses `ghr_q`; update uses `upd_hist_i`.
- Slot `i` predicts from row(`vpc_i`), bank `i`.

**Counters**
- Taken is the MSB. An update increments on taken and decrements on not-taken.
- Counters saturate at `2^CTR_WIDTH-1` and at 0.
- Init value is weakly not-taken: `2^(CTR_WIDTH-1)-1`. For 1-bit counters this is 0.

**FSM**
- INIT: row counter `r` starts at 0. Each cycle, all banks of row `r` are written with the init value and `r` increments. When `r = ROWS-1` the FSM moves to READY.
- READY: normal operation. `flush_i` goes to INIT with `r = 0` and `ghr_q = 0`.
- `rst_i` in any state goes to INIT, `r = 0`, `ghr_q = 0`.
- `flush_i` during INIT restarts the sweep at `r = 0`.

**During INIT**
- `pred_valid_o` is 0.
- Spec and update inputs are ignored.

**GHR**
- Spec: `ghr_q <= {ghr_q[HIST_LEN-2:0], spec_taken_i}`.
- Mispredict: `ghr_q <= {upd_hist_i[HIST_LEN-2:0], upd_taken_i}`.
- If both occur in the same cycle, the mispredict wins and the spec shift is discarded.
- `ghr_q` is updated even when `MODE = 0`, but is not used for indexing.

**Debug**
- `debug_mode_i` blocks counter writes only. GHR behaviour is unchanged.

## Timing
- Reset values: `ready_o = 0`, `pred_valid_o = 0`, `pred_taken_o = 0`, `pred_hist_o = 0`.
- Init takes exactly `ROWS = NR_ENTRIES/INSTR_PER_FETCH` cycles after `rst_i`/`flush_i` deasserts. `ready_o` is 1 in the cycle after the last row write.
- Predictions are combinational: zero-cycle latency from `vpc_i` and `ghr_q`.
- A counter update is written at the edge and visible to reads from the next cycle. A same-cycle read of the same entry returns the old value.
- Only one update per cycle is possible. Spec and update are processed in the same cycle with no stall.
- A `spec_valid_i` shift is visible on `pred_hist_o` the next cycle.

## Test plan
- **Init sweep:** defaults, `rst_i` high for 1 cycle, then low → `ready_o` rises after 512 cycles. Every slot then predicts not-taken with valid=1, and `pred_hist_o = 0`.
- **Saturation:** `MODE = 0`, 3× taken update on `pc = 0x80000000`:
  - counter goes 01→10→11; `pred_taken_o[0] = 1` after the 1st update;
  - a 4th taken update leaves it at 11;
  - 2× not-taken then gives 01, predicted not-taken.
- **Gshare separation:** `MODE = 1`, train PC `0x80000010` taken with `upd_hist_i = 0x00`. Then predict the same PC:
  - with `ghr_q = 0x00` → taken;
  - with `ghr_q = 0x01` → not-taken.
- **GHR repair:**
  - 4× spec taken → `ghr_q = 0x0F`;
  - mispredict with `upd_hist_i = 0x03`, `upd_taken_i = 0` → `ghr_q = 0x06`;
  - the same mispredict in the same cycle as spec taken also gives `0x06`.
- **Flush mid-INIT and in READY:**
  - `flush_i` at cycle 100 of init → `ready_o` rises 512 cycles after the flush;
  - trained counters return to 01 and the GHR returns to 0;
  - updates issued during INIT have no effect.
- **Debug and RAW:**
  - a taken update with `debug_mode_i = 1` → counter unchanged;
  - a same-cycle update and prediction of one entry → the prediction shows the old value, and the new value appears the next cycle.
